beat_recorder: RTL
==================

// Module: beat_recorder
// PURPOSE
//  Writer side of the beat-indexed score: captures one note code per beat into an internal
//  score RAM, so the playback path (beat counter -> ibeat) can read it back by beat index.
//  Sits between the keyboard/note decoder and the tone generator. Owns record FSM, write
//  pointer, recorded length and a 1-cycle-latency read port addressed by playback ibeat.
// PARAMETERS
//  LEN     4095  max beats stored; valid write indices 0..LEN-1
//  ADDR_W  12    width of beat index / length
//  NOTE_W  5     note code width; code 0 = rest
// PORTS
//  clk        in   1       system clock; single clock domain
//  reset_n    in   1       synchronous, active-low reset
//  beat_tick  in   1       1-cycle pulse per beat (same rate that advances playback ibeat)
//  rec_start  in   1       level/pulse; arms a new recording from IDLE
//  rec_stop   in   1       level/pulse; ends recording
//  note_in    in   NOTE_W  note to store; sampled only on beat_tick while armed/recording
//  rd_ibeat   in   ADDR_W  playback beat index
//  rd_note    out  NOTE_W  registered note at rd_ibeat
//  wr_ibeat   out  ADDR_W  next write index
//  rec_len    out  ADDR_W  committed length of last recording (valid when !recording)
//  recording  out  1       high in ARM and REC
//  full       out  1       high once LEN beats stored; cleared by next rec_start
//  done       out  1       1-cycle pulse when a recording commits
// BEHAVIOUR
//  - Reset (reset_n=0 at clk edge): state IDLE; wr_ibeat=0, rec_len=0, recording=0, full=0,
//    done=0, rd_note=0. RAM contents not cleared. Reset mid-recording discards it (rec_len=0).
//  - FSM states IDLE, ARM, REC, FINISH:
//    IDLE:   rec_start -> ARM; wr_ibeat<=0, rec_len<=0, full<=0. rec_stop ignored;
//            rec_start+rec_stop same cycle -> start wins.
//    ARM:    waits for first beat_tick (beat alignment). beat_tick -> mem[0]<=note_in,
//            wr_ibeat<=1, -> REC. rec_stop (no tick) -> FINISH with wr_ibeat=0.
//            rec_stop+beat_tick same cycle -> write mem[0], wr_ibeat<=1, -> FINISH.
//    REC:    each beat_tick: mem[wr_ibeat]<=note_in, wr_ibeat<=wr_ibeat+1. If the write index
//            was LEN-1 -> full<=1, -> FINISH. rec_stop -> FINISH; with simultaneous
//            beat_tick the write is performed first. rec_start ignored.
//    FINISH: rec_len<=wr_ibeat; done=1 for this single cycle; -> IDLE.
//  - recording = (state==ARM || state==REC); combinational from state register.
//  - Arithmetic: wr_ibeat never exceeds LEN; compare on ADDR_W+1 bits, no wrap-around.
//  - Read port: rd_note <= (rd_ibeat < rec_len) ? mem[rd_ibeat] : 0 every cycle, 1-cycle
//    latency. While recording, rd_note <= 0 (rest) regardless of rd_ibeat.
//  - Same-address read and write in one cycle: read returns old data (read-before-write).
//  - rec_len==0 -> rd_note is always 0.
// STRUCTURE
//  - Shared package: LEN, ADDR_W, NOTE_W, NOTE_REST=0, FSM state enum (2-bit).
//  - Sub-module score_ram: simple dual-port, 1 write port, 1 registered read port,
//    depth LEN, width NOTE_W, no reset on storage. FSM, pointer and read gating in top.
// TESTING
//  1 Reset: hold reset_n=0 3 cycles mid-REC -> recording=0, wr_ibeat=0, rec_len=0, done=0.
//  2 Basic: rec_start, 4 ticks with notes 3,5,7,0, rec_stop -> done 1 cycle, rec_len=4;
//    read rd_ibeat=0..4 -> rd_note 3,5,7,0,0 each one cycle after address.
//  3 Alignment: rec_start, 10 idle cycles, then tick note 9 -> mem[0]=9; rec_stop in ARM
//    (no tick) on a fresh run -> done, rec_len=0.
//  4 Simultaneous: in REC at wr_ibeat=2, beat_tick+rec_stop, note_in=6 -> mem[2]=6, rec_len=3.
//  5 Full: LEN=8 override, 8 ticks -> full=1, done, rec_len=8; further ticks ignored;
//    next rec_start clears full and rec_len.
//  6 Read-before-write + gating: rd_ibeat=wr_ibeat during write -> old data; rd_note=0
//    throughout recording; rec_start+rec_stop in IDLE -> ARM.

Source files
------------

// File: rtl/beat_recorder_pkg.sv
// Shared constants and FSM state type for the beat-indexed score recorder.
package beat_recorder_pkg;

    localparam int unsigned LEN_DEFAULT    = 4095;
    localparam int unsigned ADDR_W_DEFAULT = 12;
    localparam int unsigned NOTE_W_DEFAULT = 5;

    localparam logic [NOTE_W_DEFAULT-1:0] NOTE_REST = '0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARM    = 2'd1,
        ST_REC    = 2'd2,
        ST_FINISH = 2'd3
    } rec_state_e;

endpackage

// File: rtl/score_ram.sv
// Score storage: simple dual-port RAM, one write port, one registered read port.
// Read-before-write on a same-address collision; storage is never reset.
// Ports:
//   clk      - clock
//   we_i     - write enable
//   waddr_i  - write beat index
//   wdata_i  - note to store
//   raddr_i  - read beat index
//   rdata_o  - registered read data (1-cycle latency)
module score_ram #(
    parameter int unsigned DEPTH = 4095,
    parameter int unsigned AW    = 12,
    parameter int unsigned DW    = 5
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DW-1:0] mem_q [DEPTH];

    // Read samples the array before the write of the same edge lands.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i[IW-1:0]] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i[IW-1:0]];
    end

endmodule

// File: rtl/beat_recorder.sv
// Writer side of the beat-indexed score: records one note per beat_tick into
// the score RAM and serves a 1-cycle-latency read port indexed by playback beat.
// Ports:
//   clk, reset_n  - clock, synchronous active-low reset
//   beat_tick     - one-cycle pulse per beat
//   rec_start     - arms a new recording from idle
//   rec_stop      - ends the recording in progress
//   note_in       - note stored on each beat_tick while armed/recording
//   rd_ibeat      - playback beat index
//   rd_note       - note at rd_ibeat, one cycle later (rest outside the take)
//   wr_ibeat      - next write index
//   rec_len       - committed length of the last recording
//   recording     - high while armed or recording
//   full          - all LEN slots written; cleared by the next rec_start
//   done          - one-cycle pulse when a recording commits
module beat_recorder
    import beat_recorder_pkg::*;
#(
    parameter int unsigned LEN    = LEN_DEFAULT,
    parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
    parameter int unsigned NOTE_W = NOTE_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              beat_tick,
    input  logic              rec_start,
    input  logic              rec_stop,
    input  logic [NOTE_W-1:0] note_in,
    input  logic [ADDR_W-1:0] rd_ibeat,
    output logic [NOTE_W-1:0] rd_note,
    output logic [ADDR_W-1:0] wr_ibeat,
    output logic [ADDR_W-1:0] rec_len,
    output logic              recording,
    output logic              full,
    output logic              done
);

    // Index of the final slot, widened so LEN itself never wraps.
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(LEN - 1);

    rec_state_e        state_q, state_d;
    logic [ADDR_W-1:0] wr_q, wr_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic              full_q, full_d;
    logic              done_q, done_d;
    logic              gate_q, gate_d;
    logic              we_c;
    logic              recording_c;
    logic [NOTE_W-1:0] rdata;

    assign recording_c = (state_q == ST_ARM) || (state_q == ST_REC);

    // Next-state, pointer, length and read-gate logic.
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        len_d   = len_q;
        full_d  = full_q;
        done_d  = 1'b0;
        we_c    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (rec_start) begin
                    state_d = ST_ARM;
                    wr_d    = '0;
                    len_d   = '0;
                    full_d  = 1'b0;
                end
            end
            // ARM differs from REC only in staying put until the first tick;
            // wr_q is 0 in ARM, so the first note lands in slot 0.
            ST_ARM, ST_REC: begin
                if (beat_tick) begin
                    we_c    = 1'b1;
                    wr_d    = wr_q + ADDR_W'(1);
                    state_d = ST_REC;
                    if ({1'b0, wr_q} == LAST_IDX) begin
                        full_d  = 1'b1;
                        state_d = ST_FINISH;
                    end
                end
                if (rec_stop) begin
                    state_d = ST_FINISH;
                end
            end
            ST_FINISH: begin
                len_d   = wr_q;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        done_d = (state_d == ST_FINISH);
        gate_d = !recording_c && (rd_ibeat < len_q);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            wr_q    <= '0;
            len_q   <= '0;
            full_q  <= 1'b0;
            done_q  <= 1'b0;
            gate_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            len_q   <= len_d;
            full_q  <= full_d;
            done_q  <= done_d;
            gate_q  <= gate_d;
        end
    end

    score_ram #(
        .DEPTH (LEN),
        .AW    (ADDR_W),
        .DW    (NOTE_W)
    ) u_score_ram (
        .clk     (clk),
        .we_i    (we_c),
        .waddr_i (wr_q),
        .wdata_i (note_in),
        .raddr_i (rd_ibeat),
        .rdata_o (rdata)
    );

    // Gate registered alongside the RAM read, so both refer to the same edge.
    assign rd_note   = gate_q ? rdata : NOTE_W'(NOTE_REST);
    assign wr_ibeat  = wr_q;
    assign rec_len   = len_q;
    assign recording = recording_c;
    assign full      = full_q;
    assign done      = done_q;

endmodule
